set_assoc_tag_array: RTL
========================

Name: set_assoc_tag_array

Overview:
- Parametrised N-way set-associative successor to the direct-mapped tag store.
- Holds tag/valid/dirty per way plus tree-PLRU state per set.
- Performs registered tag compare and hit detection, and selects a victim on miss.
- Self-clears all state after reset with a sequential init walk. Sits between cache controller FSM and data array.

Parameters:
- TAG_BITS, 19, tag width
- NUM_SETS, 128, number of sets; power of 2, >=2
- NUM_WAYS, 4, associativity; power of 2, >=2

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- lookup_valid  in  1  lookup request; accepted only when lookup_ready=1
- lookup_ready  out  1  0 during init, 1 otherwise
- lookup_index  in  $clog2(NUM_SETS)  set index
- lookup_tag  in  TAG_BITS  tag to compare
- resp_valid  out  1  response strobe, one cycle per accepted lookup
- resp_hit  out  1  tag matched a valid way
- resp_way  out  $clog2(NUM_WAYS)  hit way, binary; lowest index on multi-hit
- resp_dirty  out  1  dirty bit of hit way; 0 on miss
- resp_multi_hit  out  1  more than one valid way matched (error flag)
- victim_way  out  $clog2(NUM_WAYS)  replacement way; meaningful on miss
- victim_valid  out  1  victim way currently valid
- victim_dirty  out  1  victim way dirty, i.e. writeback needed
- victim_tag  out  TAG_BITS  victim tag, for writeback address
- upd_we  in  1  write one way's entry
- upd_index  in  $clog2(NUM_SETS)  set to write
- upd_way  in  $clog2(NUM_WAYS)  way to write
- upd_tag  in  TAG_BITS  new tag
- upd_valid  in  1  new valid
- upd_dirty  in  1  new dirty

Behaviour:
- Clock is clk. Reset is synchronous, active-low, named rst_n.
- States: INIT and RUN.
  - rst_n=0 at any edge forces INIT with init pointer = 0. This applies mid-init and mid-operation.
  - All response outputs register to 0.
- INIT:
  - One set per cycle: clear all valid, dirty and PLRU bits of set[ptr]. Tags need not be cleared.
  - After set NUM_SETS-1 is cleared, go to RUN. First RUN cycle is exactly NUM_SETS cycles after rst_n is sampled high.
  - lookup_ready=0; lookups and upd_we are ignored.
- RUN: lookup_ready=1.
- Lookup latency is 1 cycle. An accepted lookup at edge k gives resp_* and victim_* valid in the cycle after edge k, with resp_valid=1 for that one cycle. Fully pipelined: one lookup per cycle.
- Response outputs hold their last values when resp_valid=0. On reset they are all 0.
- Hit = valid[w] && tag[w]==lookup_tag.
- Victim selection: lowest-index invalid way if any exists, else the PLRU way. Victim is computed on every lookup, hit or miss.
- PLRU encoding:
  - NUM_WAYS-1 node bits per set, heap order; node 0 is the root, children of node n are 2n+1 and 2n+2.
  - Bit value 0 means the victim is in the left subtree (lower ways); 1 means right.
  - Touching way w sets every node on its path to point away from w.
- PLRU touch events: a lookup hit touches resp_way; upd_we touches upd_way.
- Same cycle, same set, both a lookup hit and upd_we: only the upd_way touch applies.
- Lookup and upd_we to the same set in the same cycle are read-first. The response reflects state before the write; the write is visible to a lookup at the next edge.
- A miss never modifies state. The controller installs the line via upd_we.
- Flops are used for valid, dirty and PLRU so that init and read-first compare are possible. Tags may use the RAM-style array.

Decomposition:
- Package cache_pkg:
  - INDEX_BITS/WAY_BITS/PLRU_BITS derivation functions.
  - State enum {INIT, RUN}.
  - plru_victim(bits) and plru_touch(bits, way) functions.
- One sub-module, plru_tree: combinational; takes PLRU bits, touch way and touch enable; outputs victim way and next bits. Instantiated once per port path (lookup and update).

Test Plan:
- Reset: rst_n low 2 cycles, then high → lookup_ready=0 for exactly 128 cycles, then 1. Lookup idx 0, tag 0x0 → resp_hit=0, victim_way=0, victim_valid=0.
- Fill: upd_we idx 5, ways 0..3, tags 0x100..0x103, dirty 0. Lookup idx 5 tag 0x102 → next cycle resp_valid=1, resp_hit=1, resp_way=2, resp_dirty=0.
- PLRU: after fill, lookup hits on ways 0, 2, 1 in order; lookup idx 5 tag 0x1FF → resp_hit=0, victim_way=3, victim_valid=1, victim_tag=0x103.
- Dirty victim: as above but way 3 filled with dirty=1 → victim_dirty=1. Lookup tag 0x103 → resp_dirty=1.
- Read-first: same cycle, upd_we idx 5 way 1 tag 0x200 and lookup idx 5 tag 0x200 → miss. Repeat the lookup next cycle → hit, way 1.
- Mid-init reset: pull rst_n low at init cycle 40 → restart; ready 128 cycles after release. Reset during RUN with set 5 full → after re-init, lookup 0x100 misses with victim_valid=0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative tag store.
// The tree-PLRU helpers work on a fixed maximum width so one definition serves any associativity.
package cache_pkg;

  typedef enum logic {INIT, RUN} state_t;

  localparam int MAX_LEVELS = 6;
  localparam int MAX_WAYS   = 1 << MAX_LEVELS;

  typedef logic [MAX_WAYS-2:0]   plru_vec_t;
  typedef logic [MAX_LEVELS-1:0] way_ext_t;
  typedef logic [MAX_LEVELS:0]   node_t;

  function automatic int index_bits(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int way_bits(input int num_ways);
    return $clog2(num_ways);
  endfunction

  function automatic int plru_bits(input int num_ways);
    return num_ways - 1;
  endfunction

  // Walk from the root following each node bit (0 = left, 1 = right) down to a leaf.
  function automatic way_ext_t plru_victim(input plru_vec_t bits, input int levels);
    node_t node;
    node_t leaf;
    node = '0;
    for (int l = 0; l < MAX_LEVELS; l++) begin
      if (l < levels)
        node = {node[MAX_LEVELS-1:0], 1'b0} + node_t'(1) + node_t'(bits[node[MAX_LEVELS-1:0]]);
    end
    leaf = node - ((node_t'(1) << levels) - node_t'(1));
    return leaf[MAX_LEVELS-1:0];
  endfunction

  function automatic plru_vec_t plru_touch(input plru_vec_t bits, input way_ext_t way,
                                           input int levels);
    plru_vec_t res;
    node_t     node;
    way_ext_t  sh;
    logic      d;
    res  = bits;
    node = '0;
    for (int l = 0; l < MAX_LEVELS; l++) begin
      if (l < levels) begin
        sh = way >> (levels - 1 - l);
        d  = sh[0];
        res[node[MAX_LEVELS-1:0]] = ~d;
        node = {node[MAX_LEVELS-1:0], 1'b0} + node_t'(1) + node_t'(d);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/plru_tree.sv
// Combinational tree-PLRU for one set: victim from current bits, next bits after an optional touch.
module plru_tree
  import cache_pkg::*;
#(
  parameter int NUM_WAYS = 4
) (
  input  logic [NUM_WAYS-2:0]          bits_i,
  input  logic [$clog2(NUM_WAYS)-1:0]  way_i,
  input  logic                         en_i,
  output logic [$clog2(NUM_WAYS)-1:0]  victim_o,
  output logic [NUM_WAYS-2:0]          bits_o
);

  localparam int WAY_BITS  = way_bits(NUM_WAYS);
  localparam int PLRU_BITS = plru_bits(NUM_WAYS);

  plru_vec_t ext;
  plru_vec_t nxt;
  way_ext_t  way_ext;
  way_ext_t  vic;

  always_comb begin
    ext = '0;
    ext[PLRU_BITS-1:0] = bits_i;
    way_ext = '0;
    way_ext[WAY_BITS-1:0] = way_i;
    vic = plru_victim(ext, WAY_BITS);
    nxt = plru_touch(ext, way_ext, WAY_BITS);
    victim_o = vic[WAY_BITS-1:0];
    bits_o   = en_i ? nxt[PLRU_BITS-1:0] : bits_i;
  end

endmodule

// File: rtl/set_assoc_tag_array.sv
// N-way set-associative tag store: registered lookup with hit/victim report, tree-PLRU
// replacement, and a one-set-per-cycle clearing walk after reset.
module set_assoc_tag_array
  import cache_pkg::*;
#(
  parameter int TAG_BITS = 19,
  parameter int NUM_SETS = 128,
  parameter int NUM_WAYS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        lookup_valid,
  output logic                        lookup_ready,
  input  logic [$clog2(NUM_SETS)-1:0] lookup_index,
  input  logic [TAG_BITS-1:0]         lookup_tag,
  output logic                        resp_valid,
  output logic                        resp_hit,
  output logic [$clog2(NUM_WAYS)-1:0] resp_way,
  output logic                        resp_dirty,
  output logic                        resp_multi_hit,
  output logic [$clog2(NUM_WAYS)-1:0] victim_way,
  output logic                        victim_valid,
  output logic                        victim_dirty,
  output logic [TAG_BITS-1:0]         victim_tag,
  input  logic                        upd_we,
  input  logic [$clog2(NUM_SETS)-1:0] upd_index,
  input  logic [$clog2(NUM_WAYS)-1:0] upd_way,
  input  logic [TAG_BITS-1:0]         upd_tag,
  input  logic                        upd_valid,
  input  logic                        upd_dirty
);

  localparam int INDEX_BITS = index_bits(NUM_SETS);
  localparam int WAY_BITS   = way_bits(NUM_WAYS);
  localparam int PLRU_BITS  = plru_bits(NUM_WAYS);

  state_t                  state_q;
  logic [INDEX_BITS-1:0]   ptr_q;
  logic [NUM_WAYS-1:0]     valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]     dirty_q [NUM_SETS];
  logic [PLRU_BITS-1:0]    plru_q  [NUM_SETS];
  logic [TAG_BITS-1:0]     tag_q   [NUM_SETS][NUM_WAYS];

  logic                    resp_valid_q, resp_hit_q, resp_dirty_q, resp_multi_q;
  logic [WAY_BITS-1:0]     resp_way_q, victim_way_q;
  logic                    victim_valid_q, victim_dirty_q;
  logic [TAG_BITS-1:0]     victim_tag_q;

  logic                    lk_acc, upd_acc;
  logic [NUM_WAYS-1:0]     match;
  logic                    hit_d, multi_d, any_inv;
  logic [WAY_BITS-1:0]     hit_way_d, inv_way, plru_vic, victim_d;
  logic [PLRU_BITS-1:0]    lk_plru_nxt, upd_plru_nxt;

  assign lookup_ready = (state_q == RUN);
  assign lk_acc  = lookup_valid && (state_q == RUN);
  assign upd_acc = upd_we && (state_q == RUN);

  always_comb begin
    hit_d     = 1'b0;
    hit_way_d = '0;
    any_inv   = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      match[w] = valid_q[lookup_index][w] && (tag_q[lookup_index][w] == lookup_tag);
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (match[w]) begin
        hit_d     = 1'b1;
        hit_way_d = WAY_BITS'(w);
      end
      if (!valid_q[lookup_index][w]) begin
        any_inv = 1'b1;
        inv_way = WAY_BITS'(w);
      end
    end
    multi_d  = (match & (match - NUM_WAYS'(1))) != '0;
    victim_d = any_inv ? inv_way : plru_vic;
  end

  plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru_lookup (
    .bits_i   (plru_q[lookup_index]),
    .way_i    (hit_way_d),
    .en_i     (1'b1),
    .victim_o (plru_vic),
    .bits_o   (lk_plru_nxt)
  );

  logic [WAY_BITS-1:0] upd_vic_unused;

  plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru_update (
    .bits_i   (plru_q[upd_index]),
    .way_i    (upd_way),
    .en_i     (1'b1),
    .victim_o (upd_vic_unused),
    .bits_o   (upd_plru_nxt)
  );

  always_ff @(posedge clk) begin
    if (upd_acc) tag_q[upd_index][upd_way] <= upd_tag;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= INIT;
      ptr_q          <= '0;
      resp_valid_q   <= 1'b0;
      resp_hit_q     <= 1'b0;
      resp_way_q     <= '0;
      resp_dirty_q   <= 1'b0;
      resp_multi_q   <= 1'b0;
      victim_way_q   <= '0;
      victim_valid_q <= 1'b0;
      victim_dirty_q <= 1'b0;
      victim_tag_q   <= '0;
    end else begin
      resp_valid_q <= lk_acc;
      if (state_q == INIT) begin
        valid_q[ptr_q] <= '0;
        dirty_q[ptr_q] <= '0;
        plru_q[ptr_q]  <= '0;
        ptr_q          <= ptr_q + INDEX_BITS'(1);
        if (ptr_q == INDEX_BITS'(NUM_SETS - 1)) state_q <= RUN;
      end else begin
        if (lk_acc) begin
          resp_hit_q     <= hit_d;
          resp_way_q     <= hit_way_d;
          resp_dirty_q   <= hit_d && dirty_q[lookup_index][hit_way_d];
          resp_multi_q   <= multi_d;
          victim_way_q   <= victim_d;
          victim_valid_q <= valid_q[lookup_index][victim_d];
          victim_dirty_q <= valid_q[lookup_index][victim_d] && dirty_q[lookup_index][victim_d];
          victim_tag_q   <= tag_q[lookup_index][victim_d];
          if (hit_d) plru_q[lookup_index] <= lk_plru_nxt;
        end
        // Update comes last so its touch wins when both hit the same set.
        if (upd_we) begin
          valid_q[upd_index][upd_way] <= upd_valid;
          dirty_q[upd_index][upd_way] <= upd_dirty;
          plru_q[upd_index]           <= upd_plru_nxt;
        end
      end
    end
  end

  assign resp_valid     = resp_valid_q;
  assign resp_hit       = resp_hit_q;
  assign resp_way       = resp_way_q;
  assign resp_dirty     = resp_dirty_q;
  assign resp_multi_hit = resp_multi_q;
  assign victim_way     = victim_way_q;
  assign victim_valid   = victim_valid_q;
  assign victim_dirty   = victim_dirty_q;
  assign victim_tag     = victim_tag_q;

endmodule
